stream_pipeline_arbiter: RTL and testbench



---
 rtl/stream_pipeline_arbiter_pkg.sv | 35 +++
 rtl/stream_pipeline_arbiter_if.sv | 35 +++
 rtl/stream_pipeline_arbiter_credit_counter.sv | 55 +++++
 rtl/stream_pipeline_arbiter.sv | 122 ++++++++++++
 tb/tb_stream_pipeline_arbiter.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_pipeline_arbiter_pkg.sv
// Shared types, constants and the round-robin pick helper for the
// stream pipeline arbiter.
package stream_pipeline_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        PACKET = 1'b1
    } state_t;

    localparam int CREDIT_WIDTH = 8;
    localparam int MAX_REQ      = 8;

    // Returns the first valid index at or after ptr, wrapping modulo n.
    // Returns ptr itself when nothing is valid (the caller ignores it then).
    function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                           input logic [2:0] ptr,
                                           input logic [3:0] n);
        logic [3:0] sum;
        logic [3:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            sum = {1'b0, ptr} + 4'(k);
            idx = (sum >= n) ? (sum - n) : sum;
            if (!found && (4'(k) < n) && valid[idx[2:0]]) begin
                rr_pick = idx[2:0];
                found   = 1'b1;
            end else begin
                found   = found;
            end
        end
    endfunction

endpackage

// File: rtl/stream_pipeline_arbiter_if.sv
// Bundle of the requester-side and pipeline-side AXI-Stream signals.
// The slave modport is the arbiter's view, master is the traffic side.
interface stream_pipeline_arbiter_if #(
    parameter int NUM_REQUESTERS = 2,
    parameter int STREAM_WIDTH   = 32,
    parameter int KEEP_WIDTH     = 1,
    parameter int ID_WIDTH       = 1
);
    logic [NUM_REQUESTERS-1:0]              s_axis_tvalid;
    logic [NUM_REQUESTERS-1:0]              s_axis_tready;
    logic [NUM_REQUESTERS-1:0]              s_axis_tlast;
    logic [NUM_REQUESTERS*STREAM_WIDTH-1:0] s_axis_tdata;
    logic [NUM_REQUESTERS*KEEP_WIDTH-1:0]   s_axis_tkeep;

    logic                                   m_axis_tvalid;
    logic                                   m_axis_tready;
    logic                                   m_axis_tlast;
    logic [STREAM_WIDTH-1:0]                m_axis_tdata;
    logic [KEEP_WIDTH-1:0]                  m_axis_tkeep;
    logic [ID_WIDTH-1:0]                    m_axis_tid;

    modport slave (
        input  s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep,
        output s_axis_tready,
        output m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, m_axis_tid,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep,
        input  s_axis_tready,
        input  m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, m_axis_tid,
        output m_axis_tready
    );
endinterface

// File: rtl/stream_pipeline_arbiter_credit_counter.sv
// Saturating up/down counter of beats inside the pipeline, with a
// registered "counter is zero" flag for drain logic.
module credit_counter
    import stream_pipeline_arbiter_pkg::*;
#(
    parameter int MAX_IN_FLIGHT = 128
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    inc_i,
    input  logic                    dec_i,
    output logic [CREDIT_WIDTH-1:0] count_o,
    output logic                    zero_o
);
    localparam logic [CREDIT_WIDTH-1:0] MAX_C = CREDIT_WIDTH'(MAX_IN_FLIGHT);

    logic [CREDIT_WIDTH-1:0] count_q;
    logic [CREDIT_WIDTH-1:0] count_d;
    logic                    zero_q;

    // Next count: inc and dec together cancel; clamp at 0 and at the limit
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i) begin
            if (count_q != MAX_C) begin
                count_d = count_q + CREDIT_WIDTH'(1);
            end else begin
                count_d = count_q;
            end
        end else if (dec_i && !inc_i) begin
            if (count_q != CREDIT_WIDTH'(0)) begin
                count_d = count_q - CREDIT_WIDTH'(1);
            end else begin
                count_d = count_q;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register and zero flag taken from the next value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            zero_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            zero_q  <= (count_d == CREDIT_WIDTH'(0));
        end
    end

    assign count_o = count_q;
    assign zero_o  = zero_q;

endmodule

// File: rtl/stream_pipeline_arbiter.sv
// Packet-locked round-robin arbiter feeding one fixed-latency pipeline,
// with a credit limit on beats in flight and a registered output beat.
module stream_pipeline_arbiter
    import stream_pipeline_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 2,
    parameter int STREAM_WIDTH   = 32,
    parameter int KEEP_WIDTH     = 1,
    parameter int MAX_IN_FLIGHT  = 128,
    parameter int ID_WIDTH       = 1
) (
    input  logic                      aclk,
    input  logic                      resetn,
    stream_pipeline_arbiter_if.slave  axis,
    input  logic                      sigRelease,
    output logic                      released,
    output logic                      grant_active
);
    localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    localparam logic [CREDIT_WIDTH-1:0] MAX_C = CREDIT_WIDTH'(MAX_IN_FLIGHT);

    state_t                    state_q;
    logic [IDX_W-1:0]          rr_ptr_q;
    logic [IDX_W-1:0]          grant_idx_q;
    logic                      m_valid_q;
    logic                      m_last_q;
    logic [STREAM_WIDTH-1:0]   m_data_q;
    logic [KEEP_WIDTH-1:0]     m_keep_q;
    logic [ID_WIDTH-1:0]       m_id_q;

    logic [NUM_REQUESTERS-1:0] ready_s;
    logic [IDX_W-1:0]          pick_s;
    logic [IDX_W-1:0]          next_ptr_s;
    logic [CREDIT_WIDTH-1:0]   credit_s;
    logic                      beat_ok_s;
    logic                      accept_s;
    logic                      sel_last_s;
    logic [STREAM_WIDTH-1:0]   sel_data_s;
    logic [KEEP_WIDTH-1:0]     sel_keep_s;

    assign pick_s     = IDX_W'(rr_pick(8'(axis.s_axis_tvalid), 3'(rr_ptr_q),
                                       4'(NUM_REQUESTERS)));
    assign next_ptr_s = (grant_idx_q == IDX_W'(NUM_REQUESTERS - 1)) ? '0
                                                                     : grant_idx_q + IDX_W'(1);
    // A beat may enter only when the output slot frees up and credit remains
    assign beat_ok_s  = (!m_valid_q || axis.m_axis_tready) && (credit_s < MAX_C);
    assign sel_last_s = axis.s_axis_tlast[grant_idx_q];
    assign sel_data_s = axis.s_axis_tdata[int'(grant_idx_q)*STREAM_WIDTH +: STREAM_WIDTH];
    assign sel_keep_s = axis.s_axis_tkeep[int'(grant_idx_q)*KEEP_WIDTH +: KEEP_WIDTH];

    // Only the locked requester sees ready, and only while in a packet
    always_comb begin
        ready_s = '0;
        if ((state_q == PACKET) && beat_ok_s) begin
            ready_s[grant_idx_q] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    assign accept_s = axis.s_axis_tvalid[grant_idx_q] && ready_s[grant_idx_q];

    // Arbitration FSM plus the registered output beat
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
            m_keep_q    <= '0;
            m_id_q      <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (|axis.s_axis_tvalid) begin
                        grant_idx_q <= pick_s;
                        state_q     <= PACKET;
                    end
                end
                PACKET: begin
                    if (accept_s && sel_last_s) begin
                        rr_ptr_q <= next_ptr_s;
                        state_q  <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase

            if (accept_s) begin
                m_valid_q <= 1'b1;
                m_last_q  <= sel_last_s;
                m_data_q  <= sel_data_s;
                m_keep_q  <= sel_keep_s;
                m_id_q    <= ID_WIDTH'(grant_idx_q);
            end else if (axis.m_axis_tready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    credit_counter #(
        .MAX_IN_FLIGHT (MAX_IN_FLIGHT)
    ) u_credit (
        .clk_i   (aclk),
        .rst_ni  (resetn),
        .inc_i   (accept_s),
        .dec_i   (sigRelease),
        .count_o (credit_s),
        .zero_o  (released)
    );

    assign axis.s_axis_tready = ready_s;
    assign axis.m_axis_tvalid = m_valid_q;
    assign axis.m_axis_tlast  = m_last_q;
    assign axis.m_axis_tdata  = m_data_q;
    assign axis.m_axis_tkeep  = m_keep_q;
    assign axis.m_axis_tid    = m_id_q;
    assign grant_active       = (state_q == PACKET);

endmodule

// File: tb/tb_stream_pipeline_arbiter.sv
// Directed bench for stream_pipeline_arbiter: a default instance (credit
// limit 128) and a second instance with a credit limit of 4.
module tb_stream_pipeline_arbiter;
    localparam int N   = 2;
    localparam int W   = 32;
    localparam int K   = 1;
    localparam int IDW = 1;

    logic aclk = 1'b0;
    logic resetn;
    logic sig_rel, released, grant_active;
    logic sig_rel4, released4, grant_active4;

    int vectors    = 0;
    int miscompares = 0;

    stream_pipeline_arbiter_if #(.NUM_REQUESTERS(N), .STREAM_WIDTH(W), .KEEP_WIDTH(K), .ID_WIDTH(IDW)) bus ();
    stream_pipeline_arbiter_if #(.NUM_REQUESTERS(N), .STREAM_WIDTH(W), .KEEP_WIDTH(K), .ID_WIDTH(IDW)) bus4 ();

    stream_pipeline_arbiter #(.NUM_REQUESTERS(N), .STREAM_WIDTH(W), .KEEP_WIDTH(K),
                              .MAX_IN_FLIGHT(128), .ID_WIDTH(IDW)) dut (
        .aclk(aclk), .resetn(resetn), .axis(bus.slave),
        .sigRelease(sig_rel), .released(released), .grant_active(grant_active));

    stream_pipeline_arbiter #(.NUM_REQUESTERS(N), .STREAM_WIDTH(W), .KEEP_WIDTH(K),
                              .MAX_IN_FLIGHT(4), .ID_WIDTH(IDW)) dut4 (
        .aclk(aclk), .resetn(resetn), .axis(bus4.slave),
        .sigRelease(sig_rel4), .released(released4), .grant_active(grant_active4));

    always #5 aclk = ~aclk;

    // Source model state for the main instance
    logic [N-1:0] src_en;
    logic [N-1:0] acc;
    int           plen;
    int           bcnt [N];
    int           pcnt [N];
    // Source model state for the credit-limited instance
    logic         src4_en;
    logic         acc4;
    int           n4;

    function automatic logic [31:0] beat_data(input int i, input int p, input int b);
        return {4'hA, 4'(i), 8'(p), 16'h5500 + 16'(b)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            bus.s_axis_tvalid[i]        = src_en[i];
            bus.s_axis_tlast[i]         = (bcnt[i] == plen - 1);
            bus.s_axis_tdata[i*W +: W]  = beat_data(i, pcnt[i], bcnt[i]);
            bus.s_axis_tkeep[i]         = 1'b1;
        end
        bus4.s_axis_tvalid = {1'b0, src4_en};
        bus4.s_axis_tlast  = 2'b00;
        bus4.s_axis_tdata  = {32'h0000_0000, 32'hC0DE_0000 + 32'(n4)};
        bus4.s_axis_tkeep  = 2'b01;
    endtask

    // Apply inputs, let them settle and note which beats will be taken
    task automatic redrive();
        drive_src();
        #1;
        acc  = bus.s_axis_tvalid & bus.s_axis_tready;
        acc4 = bus4.s_axis_tvalid[0] & bus4.s_axis_tready[0];
    endtask

    // Advance one clock; sources move on to their next beat when taken
    task automatic clk_step();
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (bcnt[i] == plen - 1) begin
                    bcnt[i] = 0;
                    pcnt[i] = pcnt[i] + 1;
                end else begin
                    bcnt[i] = bcnt[i] + 1;
                end
            end
        end
        if (acc4) n4 = n4 + 1;
        sig_rel  = 1'b0;
        sig_rel4 = 1'b0;
        redrive();
    endtask

    task automatic clear_model();
        src_en  = '0;
        src4_en = 1'b0;
        n4      = 0;
        sig_rel = 1'b0;
        sig_rel4 = 1'b0;
        for (int i = 0; i < N; i++) begin
            bcnt[i] = 0;
            pcnt[i] = 0;
        end
    endtask

    task automatic reset_all();
        resetn = 1'b0;
        clear_model();
        #1;
        resetn = 1'b1;
        redrive();
    endtask

    logic [11:0] exp_v, exp_t, exp_l;

    initial begin
        resetn = 1'b0;
        plen   = 1;
        clear_model();
        bus.m_axis_tready  = 1'b1;
        bus4.m_axis_tready = 1'b1;
        drive_src();
        #12;
        // Reset state
        check("rst_mvalid", bus.m_axis_tvalid, 1'b0);
        check("rst_released", released, 1'b1);
        check("rst_grant_active", grant_active, 1'b0);
        check("rst_tready", bus.s_axis_tready, 2'b00);
        check("rst_tid", bus.m_axis_tid, 1'b0);
        check("rst_tdata", bus.m_axis_tdata, 32'h0);
        check("rst_tlast", bus.m_axis_tlast, 1'b0);
        check("rst_tkeep", bus.m_axis_tkeep, 1'b0);
        @(posedge aclk);
        #2;
        reset_all();

        // Round-robin alternation: two requesters, 3-beat packets
        src_en = 2'b11;
        plen   = 3;
        redrive();
        exp_v = 12'b1110_1110_1110;
        exp_t = 12'b0000_1110_0000;
        exp_l = 12'b1000_1000_1000;
        for (int k = 1; k <= 12; k++) begin
            clk_step();
            check("rr_valid", bus.m_axis_tvalid, exp_v[k-1]);
            if (exp_v[k-1]) begin
                check("rr_tid", bus.m_axis_tid, exp_t[k-1]);
                check("rr_tlast", bus.m_axis_tlast, exp_l[k-1]);
            end
        end
        src_en = 2'b00;
        redrive();
        check("rr_released_busy", released, 1'b0);
        reset_all();

        // Packet lock: requester 0 pauses mid-packet while requester 1 waits
        src_en = 2'b01;
        plen   = 4;
        redrive();
        clk_step();
        check("lock_grant", grant_active, 1'b1);
        clk_step();
        src_en = 2'b11;
        redrive();
        check("lock_rdy1_a", bus.s_axis_tready[1], 1'b0);
        clk_step();
        src_en = 2'b10;
        redrive();
        for (int p = 0; p < 5; p++) begin
            check("lock_rdy1_pause", bus.s_axis_tready[1], 1'b0);
            check("lock_held", grant_active, 1'b1);
            clk_step();
        end
        src_en = 2'b11;
        redrive();
        check("lock_idle_out", bus.m_axis_tvalid, 1'b0);
        clk_step();
        check("lock_b2_tid", bus.m_axis_tid, 1'b0);
        check("lock_b2_data", bus.m_axis_tdata, beat_data(0, 0, 2));
        check("lock_rdy1_b", bus.s_axis_tready[1], 1'b0);
        clk_step();
        check("lock_b3_data", bus.m_axis_tdata, beat_data(0, 0, 3));
        check("lock_b3_last", bus.m_axis_tlast, 1'b1);
        clk_step();
        check("lock_next_rdy1", bus.s_axis_tready[1], 1'b1);
        reset_all();

        // Backpressure: output stalled for 4 cycles with a beat pending
        src_en = 2'b01;
        plen   = 3;
        redrive();
        clk_step();
        clk_step();
        bus.m_axis_tready = 1'b0;
        redrive();
        for (int h = 0; h < 4; h++) begin
            check("bp_valid", bus.m_axis_tvalid, 1'b1);
            check("bp_data", bus.m_axis_tdata, beat_data(0, 0, 0));
            check("bp_last", bus.m_axis_tlast, 1'b0);
            check("bp_tid", bus.m_axis_tid, 1'b0);
            check("bp_no_ready", bus.s_axis_tready[0], 1'b0);
            clk_step();
        end
        check("bp_data_end", bus.m_axis_tdata, beat_data(0, 0, 0));
        bus.m_axis_tready = 1'b1;
        redrive();
        check("bp_ready_back", bus.s_axis_tready[0], 1'b1);
        clk_step();
        check("bp_next_data", bus.m_axis_tdata, beat_data(0, 0, 1));
        reset_all();

        // Credit limit of 4 with no releases, then one release
        src4_en = 1'b1;
        redrive();
        for (int k = 1; k <= 7; k++) begin
            clk_step();
            check("cred_ready", bus4.s_axis_tready[0], (k <= 4) ? 1'b1 : 1'b0);
            if (k == 5) check("cred_4th_data", bus4.m_axis_tdata, 32'hC0DE_0003);
            if (k == 7) begin
                check("cred_accepted4", 32'(n4), 32'd4);
                sig_rel4 = 1'b1;
            end
        end
        clk_step();
        check("cred_ready_after_rel", bus4.s_axis_tready[0], 1'b1);
        clk_step();
        check("cred_5th_data", bus4.m_axis_tdata, 32'hC0DE_0004);
        check("cred_accepted5", 32'(n4), 32'd5);
        src4_en = 1'b0;
        redrive();
        reset_all();

        // Release accounting: 10 accepts, 10 releases (3 coincident), 1 extra
        src_en = 2'b01;
        plen   = 10;
        redrive();
        for (int k = 1; k <= 20; k++) begin
            clk_step();
            check("rel_released", released, (k <= 1 || k >= 18) ? 1'b1 : 1'b0);
            if (k == 11) begin
                src_en = 2'b00;
                redrive();
            end
            sig_rel = (k >= 8 && k <= 18) ? 1'b1 : 1'b0;
        end
        // One more beat proves the extra release did not wrap the counter
        src_en = 2'b01;
        plen   = 1;
        redrive();
        clk_step();
        clk_step();
        check("rel_no_underflow", released, 1'b0);
        src_en  = 2'b00;
        redrive();
        sig_rel = 1'b1;
        clk_step();
        check("rel_back_to_one", released, 1'b1);
        reset_all();

        // Asynchronous reset in the middle of requester 1's packet
        src_en = 2'b01;
        plen   = 2;
        redrive();
        clk_step();
        clk_step();
        clk_step();
        src_en = 2'b10;
        redrive();
        clk_step();
        clk_step();
        check("ar_pre_valid", bus.m_axis_tvalid, 1'b1);
        check("ar_pre_tid", bus.m_axis_tid, 1'b1);
        check("ar_pre_released", released, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        check("ar_mvalid", bus.m_axis_tvalid, 1'b0);
        check("ar_released", released, 1'b1);
        check("ar_grant", grant_active, 1'b0);
        check("ar_tready", bus.s_axis_tready, 2'b00);
        resetn = 1'b1;
        clear_model();
        src_en = 2'b11;
        redrive();
        clk_step();
        clk_step();
        check("ar_restart_valid", bus.m_axis_tvalid, 1'b1);
        check("ar_restart_tid", bus.m_axis_tid, 1'b0);
        check("ar_restart_data", bus.m_axis_tdata, beat_data(0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
